// File: rtl/const_observer_pkg.sv
// Shared types and default constants for the constant-propagation observer
// and the test designs that drive it.
package const_observer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int         DEF_WIDTH  = 8;
   localparam logic [7:0] DEF_EXPECT = 8'hA5;

endpackage

// File: rtl/const_shifter.sv
// Capture register plus bit index: loads the observed vector and presents it
// one bit at a time, LSB first.
module const_shifter
   import const_observer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             advance,
   input  logic [WIDTH-1:0] d,
   output logic             so_data,
   output logic             so_last
);

   logic [WIDTH-1:0] cap;
   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap <= '0;
         idx <= '0;
      end else if (load) begin
         cap <= d;
         idx <= '0;
      end else if (advance) begin
         // advance is never asserted on the last bit, so idx cannot wrap
         idx <= idx + IDX_W'(1);
      end
   end

   assign so_data = cap[idx];
   assign so_last = (idx == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/const_observer.sv
// Observation block: captures d on request, streams it out serially over
// valid/ready, and keeps a sticky flag for any capture differing from EXPECT.
module const_observer
   import const_observer_pkg::*;
#(
   parameter int               WIDTH  = DEF_WIDTH,
   parameter logic [WIDTH-1:0] EXPECT = WIDTH'(DEF_EXPECT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample,
   input  logic [WIDTH-1:0] d,
   output logic             so_valid,
   input  logic             so_ready,
   output logic             so_data,
   output logic             so_last,
   output logic             busy,
   output logic             mismatch,
   output logic             overrun
);

   state_t state;
   logic   load;
   logic   advance;
   logic   sh_data;
   logic   sh_last;

   assign load    = (state == ST_IDLE) & sample;
   assign advance = (state == ST_SHIFT) & so_ready & ~sh_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mismatch <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sample) begin
                  state    <= ST_SHIFT;
                  mismatch <= mismatch | (d != EXPECT);
               end
            end
            ST_SHIFT: begin
               if (so_ready && sh_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   const_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .advance (advance),
      .d       (d),
      .so_data (sh_data),
      .so_last (sh_last)
   );

   // idx parks on the last bit after a word, so gate the serial outputs in IDLE
   assign busy     = (state == ST_SHIFT);
   assign so_valid = busy;
   assign so_data  = busy & sh_data;
   assign so_last  = busy & sh_last;
   assign overrun  = busy & sample;

endmodule
